sys_div_round: RTL

SYS_DIV_ROUND -- requirements
Module: sys_div_round

---
 rtl/sys_pkg_math.sv | 16 +
 rtl/sys_pkg_type.sv | 9 +
 rtl/sys_div_step.sv | 23 ++
 rtl/sys_div_round.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sys_pkg_math.sv
// Shared FSM state type and configuration legality check for the sys_div_* datapaths.
package sys_pkg_math;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StRound,
    StDone
  } sys_div_state_e;

  function automatic bit steps_legal(int unsigned width, int unsigned steps);
    return (steps == 1 || steps == 2 || steps == 4) && (width % steps == 0) &&
           (width >= 2) && (width <= 64);
  endfunction

endpackage

// File: rtl/sys_pkg_type.sv
// Shared operand and flag types for the sys_* arithmetic blocks.
package sys_pkg_type;

  localparam int unsigned SysMaxWidth = 64;

  typedef logic [SysMaxWidth-1:0] sys_word_t;
  typedef logic                   sys_flag_t;

endpackage

// File: rtl/sys_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, emit quotient bit.
module sys_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The shifted remainder needs WIDTH+1 bits; the difference always fits back in WIDTH.
  always_comb begin
    shifted = {rem_i, quot_i[WIDTH-1]};
    fits    = shifted >= {1'b0, divisor_i};
    rem_o   = fits ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    quot_o  = {quot_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/sys_div_round.sv
// Iterative unsigned divider, STEPS quotient bits per cycle, valid/ready on both sides.
// Define SYS_DIV_ROUND_EN to add a one-cycle round-half-up stage on the quotient.
module sys_div_round
  import sys_pkg_math::*;
  import sys_pkg_type::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_dividend,
  input  logic [WIDTH-1:0] s_divisor,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_quot,
  output logic [WIDTH-1:0] m_rem,
  output logic             m_dz
);

  localparam int unsigned Iters = WIDTH / STEPS;
  localparam int unsigned CntW  = $clog2(Iters + 1);

  if (!steps_legal(WIDTH, STEPS)) begin : gen_cfg_check
    $error("sys_div_round: illegal WIDTH/STEPS combination");
  end

  sys_div_state_e   state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  sys_flag_t        dz_q, dz_d;

  // quot_q doubles as the dividend shift register while calculating.
  logic [WIDTH-1:0] rem_chain  [STEPS+1];
  logic [WIDTH-1:0] quot_chain [STEPS+1];

  assign rem_chain[0]  = rem_q;
  assign quot_chain[0] = quot_q;

  for (genvar i = 0; i < STEPS; i++) begin : gen_step
    sys_div_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem_i    (rem_chain[i]),
      .quot_i   (quot_chain[i]),
      .divisor_i(divisor_q),
      .rem_o    (rem_chain[i+1]),
      .quot_o   (quot_chain[i+1])
    );
  end

`ifdef SYS_DIV_ROUND_EN
  logic round_up;
  assign round_up = {rem_q, 1'b0} >= {1'b0, divisor_q};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    dz_d      = dz_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          if (s_divisor == '0) begin
            quot_d  = '1;
            rem_d   = s_dividend;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            quot_d    = s_dividend;
            rem_d     = '0;
            divisor_d = s_divisor;
            dz_d      = 1'b0;
            cnt_d     = CntW'(Iters);
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d  = rem_chain[STEPS];
        quot_d = quot_chain[STEPS];
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
`ifdef SYS_DIV_ROUND_EN
          state_d = StRound;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef SYS_DIV_ROUND_EN
      StRound: begin
        // Divisor 1 always leaves rem 0, so the increment cannot wrap.
        quot_d  = quot_q + WIDTH'(round_up);
        state_d = StDone;
      end
`endif
      StDone: begin
        if (m_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      dz_q      <= dz_d;
    end
  end

  assign s_ready = (state_q == StIdle);
  assign m_valid = (state_q == StDone);
  assign m_quot  = quot_q;
  assign m_rem   = rem_q;
  assign m_dz    = dz_q;

endmodule
